mem_line_engine: RTL and testbench
==================================

MEM_LINE_ENGINE -- requirements
Module: mem_line_engine

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per cache line (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 6, word address width of the data memory port.
REQ-003 Parameter LW, default log2(LINE_WORDS), word-offset width; line address width is ADDR_W-LW.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 n_reset  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  line transfer request present.
REQ-007 req_ready  output  1  engine can accept a request.
REQ-008 req_write  input  1  1 = write back line to memory, 0 = fill line from memory.
REQ-009 req_line_addr  input  ADDR_W-LW  line address.
REQ-010 req_word_off  input  LW  critical word offset (fills only).
REQ-011 req_wline  input  32*LINE_WORDS  write-back data, word i at bits [32i+31:32i].
REQ-012 resp_valid  output  1  transfer complete.
REQ-013 resp_ready  input  1  requester consumes response.
REQ-014 resp_rline  output  32*LINE_WORDS  filled line, same packing as req_wline.
REQ-015 mem_address  output  ADDR_W  word address to data memory.
REQ-016 mem_wdata  output  32  store data.
REQ-017 mem_load  output  1  load strobe; memory read is combinational.
REQ-018 mem_store  output  1  store strobe; memory writes on the rising edge.
REQ-019 mem_rdata  input  32  load data, valid in the same cycle mem_load is high.

Function
REQ-020 FSM states IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: on req_valid&&req_ready, the engine SHALL latch all req_* fields and go to WRITE if req_write, else READ.
REQ-022 WRITE: for beats k=0..LINE_WORDS-1, one per cycle, the engine SHALL drive mem_store=1, mem_address={line_addr,k}, mem_wdata=latched word k.
REQ-023 READ: for beats k=0..LINE_WORDS-1, one per cycle, the engine SHALL drive mem_load=1, mem_address={line_addr,idx}, and capture mem_rdata into resp_rline word idx at the clock edge.
REQ-024 The beat counter SHALL be LW bits wide; idx = (start+k) mod LINE_WORDS, wrapping without touching the line address.
REQ-025 After the last beat the engine SHALL enter RESP; resp_valid=1 in RESP only.
REQ-026 Latency: resp_valid SHALL rise exactly LINE_WORDS+1 cycles after the accepting edge.
REQ-027 RESP: resp_rline and resp_valid SHALL hold stable until resp_ready=1; the engine then returns to IDLE on that edge.
REQ-028 A request presented while not in IDLE SHALL be ignored (not latched); the requester holds it until req_ready.
REQ-029 Outside READ/WRITE, mem_load=0, mem_store=0, mem_address=0, mem_wdata=0; mem_load and mem_store SHALL never be high together.
REQ-030 resp_rline SHALL keep the last filled line after a write-back; it is updated only in READ.

Reset
REQ-031 n_reset low SHALL immediately force IDLE, beat counter 0, latched fields 0, resp_rline 0, resp_valid 0, and all mem_* outputs 0.
REQ-032 Reset mid-transfer SHALL abort it with no further mem_store beats; stores already issued are not undone.
REQ-033 After n_reset rises, req_ready SHALL be 1 in the first cycle.

Configuration
REQ-034 Macro MEM_LINE_ENGINE_CWF_EN: when defined, fills SHALL start at start=req_word_off and wrap.
REQ-035 Without MEM_LINE_ENGINE_CWF_EN, start SHALL be 0 for fills and req_word_off SHALL be ignored.
REQ-036 Write-backs always use start=0 in both builds.

Verification
REQ-037 Write-back: line_addr=4'h3, wline words {A0,A1,A2,A3} -> mem_store at addresses 0x0C..0x0F on 4 consecutive cycles, with resp_valid on cycle 5.
REQ-038 Fill: memory 0x10..0x13 = {B0..B3}, line_addr=4'h4 -> resp_rline={B3,B2,B1,B0} (word 0 at bits [31:0]), 4 mem_load cycles, resp_valid on cycle 5.
REQ-039 CWF_EN build: fill with word_off=2 -> addresses 0x12,0x13,0x10,0x11 in that order, with the same resp_rline as REQ-038; non-CWF build -> addresses 0x10..0x13.
REQ-040 Backpressure: hold resp_ready=0 for 3 cycles -> resp_valid and resp_rline are stable; req_ready=0 and a second req_valid is not accepted until the cycle after resp_ready=1.
REQ-041 Reset during WRITE after beat 1 -> mem_store=0 immediately; memory 0x0E,0x0F unchanged; req_ready=1 after reset release.
REQ-042 Back-to-back write then fill of the same line -> the fill returns the just-written words.

Source files
------------

// File: rtl/mem_line_engine_if.sv
// Request/response and data-memory signals of mem_line_engine.
// master = requester side (also supplies load data), slave = the engine.
interface mem_line_engine_if #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 6,
    parameter int LW         = $clog2(LINE_WORDS)
) ();
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [ADDR_W-LW-1:0]       req_line_addr;
    logic [LW-1:0]              req_word_off;
    logic [32*LINE_WORDS-1:0]   req_wline;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [32*LINE_WORDS-1:0]   resp_rline;
    logic [ADDR_W-1:0]          mem_address;
    logic [31:0]                mem_wdata;
    logic                       mem_load;
    logic                       mem_store;
    logic [31:0]                mem_rdata;

    modport master (
        output req_valid, req_write, req_line_addr, req_word_off, req_wline,
               resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rline,
               mem_address, mem_wdata, mem_load, mem_store
    );

    modport slave (
        input  req_valid, req_write, req_line_addr, req_word_off, req_wline,
               resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rline,
               mem_address, mem_wdata, mem_load, mem_store
    );
endinterface

// File: rtl/mem_line_engine.sv
// Moves one cache line between a requester and a word-wide data memory, one word per cycle.
// Define MEM_LINE_ENGINE_CWF_EN to start fills at the requested critical word and wrap.
//   state | meaning
//   IDLE  | ready for a request
//   READ  | one load beat per cycle, rdata captured into the line
//   WRITE | one store beat per cycle from the latched line
//   RESP  | resp_valid held until resp_ready
module mem_line_engine #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 6,
    parameter int LW         = $clog2(LINE_WORDS)
) (
    input logic              clk,
    input logic              n_reset,
    mem_line_engine_if.slave bus
);
    localparam int            LAW       = ADDR_W - LW;
    localparam logic [LW-1:0] LAST_BEAT = LW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                   state_q;
    logic [LW-1:0]            cnt_q;
    logic [LW-1:0]            start_q;
    logic [LAW-1:0]           line_q;
    logic [32*LINE_WORDS-1:0] wline_q;
    logic [32*LINE_WORDS-1:0] rline_q;
    logic                     resp_valid_q;
    logic                     mem_load_q;
    logic                     mem_store_q;
    logic [ADDR_W-1:0]        mem_address_q;
    logic [31:0]              mem_wdata_q;

    logic [LW-1:0]            fill_start_d;
    logic [LW-1:0]            cnt_d;
    logic [LW-1:0]            idx_d;

`ifdef MEM_LINE_ENGINE_CWF_EN
    assign fill_start_d = bus.req_word_off;
`else
    logic unused_word_off;
    assign fill_start_d    = '0;
    assign unused_word_off = ^bus.req_word_off;
`endif

    // Word index wraps inside the line; the line address is never carried into.
    assign cnt_d = cnt_q + 1'b1;
    assign idx_d = start_q + cnt_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            start_q       <= '0;
            line_q        <= '0;
            wline_q       <= '0;
            rline_q       <= '0;
            resp_valid_q  <= 1'b0;
            mem_load_q    <= 1'b0;
            mem_store_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        line_q  <= bus.req_line_addr;
                        wline_q <= bus.req_wline;
                        cnt_q   <= '0;
                        if (bus.req_write) begin
                            start_q       <= '0;
                            state_q       <= WRITE;
                            mem_store_q   <= 1'b1;
                            mem_address_q <= {bus.req_line_addr, {LW{1'b0}}};
                            mem_wdata_q   <= bus.req_wline[31:0];
                        end else begin
                            start_q       <= fill_start_d;
                            state_q       <= READ;
                            mem_load_q    <= 1'b1;
                            mem_address_q <= {bus.req_line_addr, fill_start_d};
                        end
                    end
                end
                WRITE: begin
                    if (cnt_q == LAST_BEAT) begin
                        state_q       <= RESP;
                        resp_valid_q  <= 1'b1;
                        mem_store_q   <= 1'b0;
                        mem_address_q <= '0;
                        mem_wdata_q   <= '0;
                    end else begin
                        cnt_q         <= cnt_d;
                        mem_address_q <= {line_q, cnt_d};
                        mem_wdata_q   <= wline_q[32*cnt_d +: 32];
                    end
                end
                READ: begin
                    rline_q[32*mem_address_q[LW-1:0] +: 32] <= bus.mem_rdata;
                    if (cnt_q == LAST_BEAT) begin
                        state_q       <= RESP;
                        resp_valid_q  <= 1'b1;
                        mem_load_q    <= 1'b0;
                        mem_address_q <= '0;
                    end else begin
                        cnt_q         <= cnt_d;
                        mem_address_q <= {line_q, idx_d};
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rline  = rline_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_load    = mem_load_q;
    assign bus.mem_store   = mem_store_q;
endmodule

// File: tb/tb_mem_line_engine.sv
// Scoreboard bench for mem_line_engine: expected memory beats and responses are queued
// when a request is driven and popped by a negedge monitor as the engine produces them.
module tb_mem_line_engine;
    localparam int LINE_WORDS = 4;
    localparam int ADDR_W     = 6;
    localparam int LW         = 2;

    typedef struct {
        bit          st;
        logic [5:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic clk     = 1'b0;
    logic n_reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    beat_t        beat_q[$];
    logic [127:0] resp_q[$];
    logic [31:0]  mem     [64];
    logic [31:0]  exp_mem [64];
    logic [127:0] last_fill = '0;

    logic         nx_wr;
    logic [3:0]   nx_line;
    logic [1:0]   nx_off;
    logic [127:0] nx_wl;

    mem_line_engine_if #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W), .LW(LW)) bus_if ();

    mem_line_engine #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W), .LW(LW)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    assign bus_if.mem_rdata = bus_if.mem_load ? mem[bus_if.mem_address] : 32'h0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
        for (int k = 0; k < 4; k++) mem[16+k] = 32'hB0B0_00B0 + k;
        forever begin
            @(posedge clk);
            if (bus_if.mem_store) mem[bus_if.mem_address] <= bus_if.mem_wdata;
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (n_reset) begin
            check_val("mem_excl", bus_if.mem_load && bus_if.mem_store, 0);
            if (bus_if.mem_load || bus_if.mem_store) begin
                check_val("beat_pending", beat_q.size() != 0, 1);
                if (beat_q.size() != 0) begin
                    b = beat_q.pop_front();
                    check_val("beat_kind", bus_if.mem_store, b.st);
                    check_val("beat_addr", bus_if.mem_address, b.addr);
                    if (b.st) check_val("beat_wdata", bus_if.mem_wdata, b.data);
                end
            end else begin
                check_val("mem_idle", {bus_if.mem_address, bus_if.mem_wdata}, 0);
            end
            if (bus_if.resp_valid && bus_if.resp_ready) begin
                check_val("resp_pending", resp_q.size() != 0, 1);
                if (resp_q.size() != 0) check_val("resp_rline", bus_if.resp_rline, resp_q.pop_front());
            end
        end
    end

    function automatic logic [1:0] fill_start(input logic [1:0] off);
`ifdef MEM_LINE_ENGINE_CWF_EN
        return off;
`else
        return 2'd0;
`endif
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus_if.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("req_ready_wait", bus_if.req_ready, 1);
    endtask

    // Runs one transfer; with chain set, the next request (nx_*) is held on the bus during RESP.
    task automatic do_req(input bit wr, input logic [3:0] line, input logic [1:0] off,
                          input logic [127:0] wl, input int hold, input bit chain);
        logic [1:0]   st;
        logic [1:0]   idx;
        logic [5:0]   a;
        logic [127:0] exp_line;
        beat_t        b;
        wait_ready();
        st       = wr ? 2'd0 : fill_start(off);
        exp_line = last_fill;
        for (int k = 0; k < 4; k++) begin
            idx    = st + 2'(k);
            a      = {line, idx};
            b.st   = wr;
            b.addr = a;
            b.data = wr ? wl[32*idx +: 32] : 32'h0;
            beat_q.push_back(b);
            if (wr) exp_mem[a] = wl[32*idx +: 32];
            else    exp_line[32*idx +: 32] = exp_mem[a];
        end
        if (!wr) last_fill = exp_line;
        resp_q.push_back(exp_line);
        bus_if.req_write     = wr;
        bus_if.req_line_addr = line;
        bus_if.req_word_off  = off;
        bus_if.req_wline     = wl;
        bus_if.req_valid     = 1'b1;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        check_val("req_ready_busy", bus_if.req_ready, 0);
        // resp_valid must appear in the fifth cycle after acceptance, not earlier
        for (int c = 1; c <= LINE_WORDS; c++) begin
            @(posedge clk); #1;
            check_val("resp_latency", bus_if.resp_valid, c == LINE_WORDS);
        end
        if (chain) begin
            bus_if.req_write     = nx_wr;
            bus_if.req_line_addr = nx_line;
            bus_if.req_word_off  = nx_off;
            bus_if.req_wline     = nx_wl;
            bus_if.req_valid     = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            check_val("hold_valid", bus_if.resp_valid, 1);
            check_val("hold_rline", bus_if.resp_rline, exp_line);
            check_val("hold_busy", bus_if.req_ready, 0);
            @(posedge clk); #1;
        end
        bus_if.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.resp_ready = 1'b0;
        check_val("resp_drop", bus_if.resp_valid, 0);
        check_val("ready_back", bus_if.req_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] wl;
        beat_t        b;
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'hC0DE_0000 + i;
        for (int k = 0; k < 4; k++) exp_mem[16+k] = 32'hB0B0_00B0 + k;
        bus_if.req_valid     = 1'b0;
        bus_if.req_write     = 1'b0;
        bus_if.req_line_addr = '0;
        bus_if.req_word_off  = '0;
        bus_if.req_wline     = '0;
        bus_if.resp_ready    = 1'b0;

        #12;
        check_val("rst_store", bus_if.mem_store, 0);
        check_val("rst_load", bus_if.mem_load, 0);
        check_val("rst_addr", bus_if.mem_address, 0);
        check_val("rst_resp_valid", bus_if.resp_valid, 0);
        check_val("rst_rline", bus_if.resp_rline, 0);
        @(posedge clk); #1;
        n_reset = 1'b1;
        check_val("rst_ready", bus_if.req_ready, 1);
        @(posedge clk); #1;

        // write-back of line 3, then fill of line 4 with backpressure and a queued write
        do_req(1'b1, 4'h3, 2'd1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 1'b0);
        nx_wr = 1'b1; nx_line = 4'h5; nx_off = 2'd0;
        nx_wl = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
        do_req(1'b0, 4'h4, 2'd2, '0, 3, 1'b1);
        do_req(nx_wr, nx_line, nx_off, nx_wl, 0, 1'b0);
        do_req(1'b0, 4'h5, 2'd1, '0, 1, 1'b0);
        do_req(1'b0, 4'h3, 2'd3, '0, 0, 1'b0);

        // reset in the middle of a write-back, after beat 1 has been stored
        wl = {32'hDD03, 32'hDD02, 32'hDD01, 32'hDD00};
        wait_ready();
        for (int k = 0; k < 2; k++) begin
            b.st   = 1'b1;
            b.addr = {4'h3, 2'(k)};
            b.data = wl[32*k +: 32];
            beat_q.push_back(b);
            exp_mem[12+k] = wl[32*k +: 32];
        end
        bus_if.req_write     = 1'b1;
        bus_if.req_line_addr = 4'h3;
        bus_if.req_wline     = wl;
        bus_if.req_valid     = 1'b1;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        n_reset = 1'b0;
        #1;
        check_val("abort_store", bus_if.mem_store, 0);
        check_val("abort_addr", bus_if.mem_address, 0);
        check_val("abort_wdata", bus_if.mem_wdata, 0);
        check_val("abort_rline", bus_if.resp_rline, 0);
        check_val("abort_ready", bus_if.req_ready, 1);
        check_val("abort_beats_left", beat_q.size(), 0);
        last_fill = '0;
        @(posedge clk);
        @(posedge clk); #1;
        n_reset = 1'b1;
        check_val("abort_ready_rel", bus_if.req_ready, 1);
        check_val("mem_0C", mem[12], exp_mem[12]);
        check_val("mem_0E", mem[14], exp_mem[14]);
        check_val("mem_0F", mem[15], exp_mem[15]);
        @(posedge clk); #1;
        do_req(1'b0, 4'h3, 2'd0, '0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            wl = {$urandom, $urandom, $urandom, $urandom};
            do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   wl, int'($urandom_range(0, 2)), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check_val("beats_drained", beat_q.size(), 0);
        check_val("resps_drained", resp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
